// File: rtl/persiana_motor_ctrl.sv
// persiana_motor_ctrl -- blind motor drive controller.
// Resolves manual/automatic raise and lower requests, drives the motor in one
// direction at a time, stops at the limit switches, inserts a motor-off dead
// time between any stop and the next start, and latches a fault when both limit
// switches read active together.
// Optional build macro PERSIANA_TIMEOUT_EN adds a travel timeout that faults a
// motion lasting TIMEOUT_CYC cycles; without it motion is unbounded.
module persiana_motor_ctrl #(
    parameter int DEAD_CYC    = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CW          = 16
) (
    input  logic Reloj,
    input  logic reset,
    input  logic auto_subir,
    input  logic auto_bajar,
    input  logic man_subir,
    input  logic man_bajar,
    input  logic Ssup,
    input  logic Sinf,
    input  logic borrar_falla,
    output logic motor_subir,
    output logic motor_bajar,
    output logic ocupado,
    output logic falla
);

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        MUERTO   = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        REQ_STOP  = 2'd0,
        REQ_SUBIR = 2'd1,
        REQ_BAJAR = 2'd2
    } req_t;

    // Dead counter counts down to zero, so MUERTO spans exactly DEAD_CYC cycles.
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    req_t          req;
    logic          sensor_fault;

    estado_t       state_q, state_d;
    logic [CW-1:0] dead_q, dead_d;
    logic          motor_subir_q, motor_bajar_q, ocupado_q, falla_q;

`ifdef PERSIANA_TIMEOUT_EN
    localparam logic [CW-1:0] TRAV_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] trav_q, trav_d;
    logic          trav_expired;

    assign trav_expired = (trav_q == TRAV_LAST);
`else
    // Timeout length has no effect in this build; fold it into a sink signal.
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^CW'(TIMEOUT_CYC);
`endif

    // Both limit switches active at once is physically impossible: wiring fault.
    assign sensor_fault = Ssup & Sinf;

    // Request arbitration: a single manual button wins, two manual buttons stop,
    // otherwise a single automatic request is honoured.
    always_comb begin
        req = REQ_STOP;
        if (man_subir && !man_bajar) begin
            req = REQ_SUBIR;
        end else if (man_bajar && !man_subir) begin
            req = REQ_BAJAR;
        end else if (!man_subir && !man_bajar) begin
            if (auto_subir && !auto_bajar) begin
                req = REQ_SUBIR;
            end else if (auto_bajar && !auto_subir) begin
                req = REQ_BAJAR;
            end
        end
    end

    // Next-state and counter logic; sensor fault overrides every transition.
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
`ifdef PERSIANA_TIMEOUT_EN
        trav_d  = trav_q;
`endif
        if (sensor_fault) begin
            state_d = FALLA;
        end else begin
            unique case (state_q)
                REPOSO: begin
                    // Requests toward an already reached limit are dropped.
                    if (req == REQ_SUBIR && !Ssup) begin
                        state_d = SUBIENDO;
`ifdef PERSIANA_TIMEOUT_EN
                        trav_d  = '0;
`endif
                    end else if (req == REQ_BAJAR && !Sinf) begin
                        state_d = BAJANDO;
`ifdef PERSIANA_TIMEOUT_EN
                        trav_d  = '0;
`endif
                    end
                end
                SUBIENDO: begin
                    // Limit reached, stop request or reversal all pass through dead time.
                    if (Ssup || req != REQ_SUBIR) begin
                        state_d = MUERTO;
                        dead_d  = DEAD_LOAD;
                    end
                end
                BAJANDO: begin
                    if (Sinf || req != REQ_BAJAR) begin
                        state_d = MUERTO;
                        dead_d  = DEAD_LOAD;
                    end
                end
                MUERTO: begin
                    // Requests are ignored here and re-evaluated once back in REPOSO.
                    if (dead_q == '0) begin
                        state_d = REPOSO;
                    end else begin
                        dead_d = dead_q - CNT_ONE;
                    end
                end
                FALLA: begin
                    // Clear is only honoured once the sensor conflict is gone.
                    if (borrar_falla) begin
                        state_d = REPOSO;
                    end
                end
                default: begin
                    state_d = REPOSO;
                end
            endcase
`ifdef PERSIANA_TIMEOUT_EN
            // A motion that keeps going past its travel budget is treated as stuck.
            if ((state_q == SUBIENDO || state_q == BAJANDO) && state_d == state_q) begin
                if (trav_expired) begin
                    state_d = FALLA;
                end else begin
                    trav_d = trav_q + CNT_ONE;
                end
            end
`endif
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so the
    // motor drive follows a request with one cycle of latency.
    always_ff @(posedge Reloj) begin
        if (!reset) begin
            state_q       <= REPOSO;
            dead_q        <= '0;
`ifdef PERSIANA_TIMEOUT_EN
            trav_q        <= '0;
`endif
            motor_subir_q <= 1'b0;
            motor_bajar_q <= 1'b0;
            ocupado_q     <= 1'b0;
            falla_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dead_q        <= dead_d;
`ifdef PERSIANA_TIMEOUT_EN
            trav_q        <= trav_d;
`endif
            motor_subir_q <= (state_d == SUBIENDO);
            motor_bajar_q <= (state_d == BAJANDO);
            ocupado_q     <= (state_d != REPOSO);
            falla_q       <= (state_d == FALLA);
        end
    end

    assign motor_subir = motor_subir_q;
    assign motor_bajar = motor_bajar_q;
    assign ocupado     = ocupado_q;
    assign falla       = falla_q;

endmodule

// File: tb/tb_persiana_motor_ctrl.sv
// Self-checking bench for persiana_motor_ctrl (DEAD_CYC=4, TIMEOUT_CYC=20).
// Each row drives one cycle of inputs and queues the outputs expected after the
// next rising edge; the row's task pops and compares them one edge later.
module tb_persiana_motor_ctrl;

    localparam int DEAD_CYC    = 4;
    localparam int TIMEOUT_CYC = 20;

    // Input vector layout: {reset, auto_subir, auto_bajar, man_subir, man_bajar, Ssup, Sinf, borrar_falla}
    localparam logic [7:0] RUN = 8'h80;
    localparam logic [7:0] AU  = 8'h40;
    localparam logic [7:0] AB  = 8'h20;
    localparam logic [7:0] MU  = 8'h10;
    localparam logic [7:0] MB  = 8'h08;
    localparam logic [7:0] SS  = 8'h04;
    localparam logic [7:0] SI  = 8'h02;
    localparam logic [7:0] BF  = 8'h01;

    // Expected outputs: {motor_subir, motor_bajar, ocupado, falla}
    localparam logic [3:0] E_R = 4'b0000;
    localparam logic [3:0] E_S = 4'b1010;
    localparam logic [3:0] E_B = 4'b0110;
    localparam logic [3:0] E_M = 4'b0010;
    localparam logic [3:0] E_F = 4'b0011;

    logic Reloj = 1'b0;
    logic reset, auto_subir, auto_bajar, man_subir, man_bajar, Ssup, Sinf, borrar_falla;
    logic motor_subir, motor_bajar, ocupado, falla;

    logic [3:0]  sb [$];
    logic [11:0] rows [$];
    int n_tests = 0;
    int n_fail  = 0;

    persiana_motor_ctrl #(
        .DEAD_CYC   (DEAD_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CW         (16)
    ) dut (
        .Reloj       (Reloj),
        .reset       (reset),
        .auto_subir  (auto_subir),
        .auto_bajar  (auto_bajar),
        .man_subir   (man_subir),
        .man_bajar   (man_bajar),
        .Ssup        (Ssup),
        .Sinf        (Sinf),
        .borrar_falla(borrar_falla),
        .motor_subir (motor_subir),
        .motor_bajar (motor_bajar),
        .ocupado     (ocupado),
        .falla       (falla)
    );

    always #5 Reloj = ~Reloj;

    task automatic apply(input logic [7:0] v, input logic [3:0] e);
        {reset, auto_subir, auto_bajar, man_subir, man_bajar, Ssup, Sinf, borrar_falla} = v;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [3:0] got, expv;
        rows = '{ {8'h00, E_R}, {AU, E_R}, {SS | SI, E_R}, {RUN, E_R} };
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL reset row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    task automatic test_raise_limit();
        logic [3:0] got, expv;
        rows = '{ {RUN | AU, E_S}, {RUN | AU, E_S},
                  {RUN | AU | SS, E_M}, {RUN | AU | SS, E_M}, {RUN | AU | SS, E_M}, {RUN | AU | SS, E_M},
                  {RUN | AU | SS, E_R}, {RUN | AU | SS, E_R}, {RUN, E_R} };
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL raise_limit row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    task automatic test_reverse();
        logic [3:0] got, expv;
        rows = '{ {RUN | AU, E_S},
                  {RUN | AU | MB, E_M}, {RUN | AU | MB, E_M}, {RUN | AU | MB, E_M}, {RUN | AU | MB, E_M},
                  {RUN | MB, E_R}, {RUN | MB, E_B}, {RUN | MB, E_B},
                  {RUN, E_M}, {RUN | AU, E_M}, {RUN | AB, E_M}, {RUN, E_M}, {RUN, E_R} };
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL reverse row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] got, expv;
        rows = '{ {RUN | AB | MU, E_S},
                  {RUN, E_M}, {RUN, E_M}, {RUN, E_M}, {RUN, E_M}, {RUN, E_R},
                  {RUN | AU | MU | MB, E_R}, {RUN | AU | AB, E_R}, {RUN | AB | SI, E_R},
                  {RUN | AU | MB, E_B}, {RUN | AU | MB | SI, E_M},
                  {RUN, E_M}, {RUN, E_M}, {RUN, E_M}, {RUN, E_R} };
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL priority row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    task automatic test_fault();
        logic [3:0] got, expv;
        rows = '{ {RUN | AB, E_B}, {RUN | AB | SS | SI, E_F}, {RUN | SS | SI | BF, E_F},
                  {RUN | AB, E_F}, {RUN | BF, E_R}, {RUN | AB | BF, E_B},
                  {RUN, E_M}, {RUN | SS | SI, E_F}, {RUN | BF, E_R},
                  {RUN | SS | SI, E_F}, {RUN | SS | SI | BF, E_F}, {RUN | BF, E_R}, {RUN, E_R} };
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL fault row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, expv;
        rows = '{ {RUN | AU, E_S}, {AU, E_R}, {RUN | AU, E_S},
                  {RUN, E_M}, {RUN, E_M}, {8'h00, E_R}, {RUN | AB, E_B},
                  {SS | SI, E_R}, {RUN, E_R} };
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL reset_mid row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    task automatic test_long_motion();
        logic [3:0] got, expv;
        rows = {};
`ifdef PERSIANA_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT_CYC; k++) rows.push_back({RUN | AU, E_S});
        rows.push_back({RUN | AU, E_F});
        rows.push_back({RUN | BF, E_R});
`else
        for (int k = 0; k < 110; k++) rows.push_back({RUN | AU, E_S});
        for (int k = 0; k < DEAD_CYC; k++) rows.push_back({RUN, E_M});
        rows.push_back({RUN, E_R});
`endif
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i][11:4], rows[i][3:0]);
            @(posedge Reloj); #1;
            got  = {motor_subir, motor_bajar, ocupado, falla};
            expv = sb.pop_front();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL long_motion row %0d: got %b required %b", i, got, expv);
            end
        end
    endtask

    initial begin
        {reset, auto_subir, auto_bajar, man_subir, man_bajar, Ssup, Sinf, borrar_falla} = 8'h00;
        test_reset();
        test_raise_limit();
        test_reverse();
        test_priority();
        test_fault();
        test_reset_mid();
        test_long_motion();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
